// File: rtl/ppu_fb_writer.sv
// Packs accepted PPU pixels four-to-a-byte through the BG palette and queues
// {addr,data} framebuffer writes in a small FIFO with a valid/ready RAM port.
module ppu_fb_writer #(
    parameter logic [12:0] FB_BASE     = 13'h0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          LINE_PIXELS = 160,
    parameter int          LINES       = 144
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  px_in,
    input  logic        px_valid,
    input  logic [1:0]  ppu_mode,
    input  logic [7:0]  bgp,
    output logic        fb_wr_valid,
    input  logic        fb_wr_ready,
    output logic [12:0] fb_wr_addr,
    output logic [7:0]  fb_wr_data,
    output logic        frame_done,
    output logic [7:0]  line_count,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // SCAN (2) only matters as "not DRAW", so it needs no named constant.
    localparam logic [1:0] H_BLANK = 2'd0;
    localparam logic [1:0] V_BLANK = 2'd1;
    localparam logic [1:0] DRAW    = 2'd3;

    localparam logic [8:0] X_MAX = 9'(LINE_PIXELS);
    localparam logic [7:0] L_MAX = 8'(LINES);

    logic [8:0]  x;
    logic [7:0]  partial;
    logic [1:0]  prev_mode;
    logic [1:0]  shade;
    logic [7:0]  next_byte;
    logic        accept;
    logic        line_end;
    logic        frame_end;
    logic        group_last;
    logic        push;
    logic [7:0]  push_data;
    logic [12:0] push_addr;

    always_comb begin
        shade = 2'd0;
        case (px_in)
            2'd0: shade = bgp[1:0];
            2'd1: shade = bgp[3:2];
            2'd2: shade = bgp[5:4];
            2'd3: shade = bgp[7:6];
            default: shade = 2'd0;
        endcase
    end

    assign accept     = px_valid && (ppu_mode == DRAW) && (x < X_MAX) && (line_count < L_MAX);
    assign line_end   = (prev_mode == DRAW) && (ppu_mode != DRAW);
    assign frame_end  = (prev_mode != V_BLANK) && (ppu_mode == V_BLANK);
    assign group_last = (x[1:0] == 2'd3);

    // First pixel of a group lands in [7:6]; unused low bits stay zero.
    assign next_byte = partial | ({shade, 6'b0} >> {x[1:0], 1'b0});

    // accept and line_end are exclusive (DRAW vs. not DRAW), so one address serves both.
    assign push      = (accept && group_last) || (line_end && (x[1:0] != 2'd0));
    assign push_data = accept ? next_byte : partial;
    assign push_addr = FB_BASE + 13'(line_count) * 13'd40 + 13'(x[8:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            partial    <= '0;
            line_count <= '0;
            prev_mode  <= H_BLANK;
            frame_done <= 1'b0;
        end else begin
            prev_mode  <= ppu_mode;
            frame_done <= frame_end;
            if (accept) begin
                x       <= x + 9'd1;
                partial <= group_last ? 8'd0 : next_byte;
            end
            if (line_end) begin
                x       <= '0;
                partial <= '0;
                if (line_count < L_MAX)
                    line_count <= line_count + 8'd1;
            end
            // Frame end wins so a coincident line end still leaves line_count at 0.
            if (frame_end) begin
                x          <= '0;
                partial    <= '0;
                line_count <= '0;
            end
        end
    end

    logic [20:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        do_push;
    logic [20:0] head;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && fb_wr_ready;
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    assign fb_wr_valid = !empty;
    assign fb_wr_addr  = fb_wr_valid ? head[20:8] : 13'd0;
    assign fb_wr_data  = fb_wr_valid ? head[7:0]  : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= {push_addr, push_data};
    end

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: single-group vectors from a table plus
// hand-written sequences for FIFO backpressure, line/frame events and reset.
module tb_ppu_fb_writer;

    logic        clk;
    logic        rst;
    logic [1:0]  px_in;
    logic        px_valid;
    logic [1:0]  ppu_mode;
    logic [7:0]  bgp;
    logic        fb_wr_valid;
    logic        fb_wr_ready;
    logic [12:0] fb_wr_addr;
    logic [7:0]  fb_wr_data;
    logic        frame_done;
    logic [7:0]  line_count;
    logic        overflow;

    ppu_fb_writer dut (
        .clk         (clk),
        .rst         (rst),
        .px_in       (px_in),
        .px_valid    (px_valid),
        .ppu_mode    (ppu_mode),
        .bgp         (bgp),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .frame_done  (frame_done),
        .line_count  (line_count),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Completed RAM writes as {addr,data}, captured mid-cycle.
    logic [20:0] wq[$];
    always @(negedge clk) begin
        if (!rst && fb_wr_valid && fb_wr_ready)
            wq.push_back({fb_wr_addr, fb_wr_data});
    end

    typedef struct {
        logic [7:0]  bgp;
        int          line;
        logic [7:0]  pix;   // pixel 0 in [7:6]
        logic [12:0] addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic send_px(input logic [1:0] p);
        ppu_mode = 2'd3;
        px_in    = p;
        px_valid = 1'b1;
        tick();
        px_valid = 1'b0;
    endtask

    task automatic line_end();
        ppu_mode = 2'd3;
        tick();
        ppu_mode = 2'd0;
        tick();
    endtask

    task automatic check_write(input string name, input int idx,
                               input logic [12:0] addr, input logic [7:0] data);
        logic [20:0] w;
        w = (idx < wq.size()) ? wq[idx] : 21'h1FFFFF;
        check({name, "_addr"}, 32'(w[20:8]), 32'(addr));
        check({name, "_data"}, 32'(w[7:0]), 32'(data));
    endtask

    initial begin
        vecs[0] = '{bgp: 8'hE4, line: 0, pix: 8'b00_01_10_11, addr: 13'h0000, data: 8'h1B};
        vecs[1] = '{bgp: 8'h1B, line: 2, pix: 8'b00_00_11_11, addr: 13'h0050, data: 8'hF0};
        vecs[2] = '{bgp: 8'hE4, line: 1, pix: 8'b11_10_01_00, addr: 13'h0028, data: 8'hE4};
        vecs[3] = '{bgp: 8'h9C, line: 3, pix: 8'b01_10_11_00, addr: 13'h0078, data: 8'hD8};
        vecs[4] = '{bgp: 8'h00, line: 0, pix: 8'b11_11_11_11, addr: 13'h0000, data: 8'h00};

        rst = 1'b1;
        px_in = 2'd0;
        px_valid = 1'b0;
        ppu_mode = 2'd0;
        bgp = 8'hE4;
        fb_wr_ready = 1'b1;

        do_reset();
        check("rst_valid", 32'(fb_wr_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_line_count", 32'(line_count), 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            bgp = vecs[v].bgp;
            fb_wr_ready = 1'b1;
            for (int l = 0; l < vecs[v].line; l++) line_end();
            for (int i = 0; i < 4; i++) begin
                logic [7:0] pv;
                pv = vecs[v].pix >> (6 - 2 * i);
                send_px(pv[1:0]);
            end
            check($sformatf("vec%0d_valid", v), 32'(fb_wr_valid), 32'd1);
            check($sformatf("vec%0d_addr", v), 32'(fb_wr_addr), 32'(vecs[v].addr));
            check($sformatf("vec%0d_data", v), 32'(fb_wr_data), 32'(vecs[v].data));
        end

        // Backpressure: 5 bytes into a 4-deep FIFO with the RAM stalled.
        do_reset();
        bgp = 8'hE4;
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 20; i++) send_px(2'd3);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_hold_addr", 32'(fb_wr_addr), 32'd0);
        check("ovf_hold_data", 32'(fb_wr_data), 32'hFF);
        fb_wr_ready = 1'b1;
        ppu_mode = 2'd0;
        repeat (8) tick();
        check("ovf_writes", 32'(wq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check_write($sformatf("ovf_w%0d", i), i, 13'(i), 8'hFF);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Push and pop in the same cycle while full: nothing is lost.
        do_reset();
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 19; i++) send_px(2'd3);
        fb_wr_ready = 1'b1;
        send_px(2'd3);
        ppu_mode = 2'd0;
        repeat (8) tick();
        check("fullpop_writes", 32'(wq.size()), 32'd5);
        check_write("fullpop_w4", 4, 13'd4, 8'hFF);
        check("fullpop_overflow", 32'(overflow), 32'd0);

        // Short line flushes a zero-padded partial group.
        do_reset();
        for (int i = 0; i < 6; i++) send_px(2'd1);
        ppu_mode = 2'd0;
        tick();
        repeat (4) tick();
        check("short_writes", 32'(wq.size()), 32'd2);
        check_write("short_w0", 0, 13'd0, 8'h55);
        check_write("short_w1", 1, 13'd1, 8'h50);
        check("short_line_count", 32'(line_count), 32'd1);

        // Full line plus one extra pixel.
        do_reset();
        for (int i = 0; i < 161; i++) send_px(2'(i % 4));
        ppu_mode = 2'd0;
        repeat (5) tick();
        check("full_writes", 32'(wq.size()), 32'd40);
        for (int i = 0; i < 40; i++)
            check_write($sformatf("full_w%0d", i), i, 13'(i), 8'h1B);
        check("full_overflow", 32'(overflow), 32'd0);

        // Pixels outside DRAW are ignored.
        do_reset();
        ppu_mode = 2'd2;
        px_in = 2'd3;
        px_valid = 1'b1;
        repeat (4) tick();
        px_valid = 1'b0;
        repeat (4) tick();
        check("scan_ignored", 32'(wq.size()), 32'd0);

        // Frame end pulse.
        do_reset();
        repeat (3) line_end();
        check("frame_pre_lines", 32'(line_count), 32'd3);
        ppu_mode = 2'd1;
        tick();
        check("frame_done_hi", 32'(frame_done), 32'd1);
        check("frame_line_clr", 32'(line_count), 32'd0);
        tick();
        check("frame_done_lo", 32'(frame_done), 32'd0);

        // DRAW straight into V_BLANK: line-end flush still happens.
        do_reset();
        send_px(2'd2);
        send_px(2'd2);
        ppu_mode = 2'd1;
        tick();
        check("coinc_frame_done", 32'(frame_done), 32'd1);
        check("coinc_line_count", 32'(line_count), 32'd0);
        repeat (4) tick();
        check("coinc_writes", 32'(wq.size()), 32'd1);
        check_write("coinc_w0", 0, 13'd0, 8'hA0);

        // line_count saturates; lines past the frame accept nothing.
        do_reset();
        repeat (150) line_end();
        check("sat_line_count", 32'(line_count), 32'd144);
        for (int i = 0; i < 4; i++) send_px(2'd3);
        repeat (4) tick();
        check("sat_no_write", 32'(wq.size()), 32'd0);

        // Reset mid-line with a queued byte and two pending pixels.
        do_reset();
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_px(2'd1);
        rst = 1'b1;
        ppu_mode = 2'd0;
        tick();
        rst = 1'b0;
        fb_wr_ready = 1'b1;
        repeat (6) tick();
        check("rstmid_writes", 32'(wq.size()), 32'd0);
        check("rstmid_valid", 32'(fb_wr_valid), 32'd0);
        check("rstmid_addr", 32'(fb_wr_addr), 32'd0);
        check("rstmid_data", 32'(fb_wr_data), 32'd0);
        check("rstmid_frame_done", 32'(frame_done), 32'd0);
        check("rstmid_line_count", 32'(line_count), 32'd0);
        check("rstmid_overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ppu_fb_writer.md
PPU_FB_WRITER -- requirements
Module: ppu_fb_writer

Interface
REQ-001 The block SHALL have parameter FB_BASE, default 13'h0000: framebuffer byte base address.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: write FIFO entries (power of two).
REQ-003 The block SHALL have parameter LINE_PIXELS, default 160: visible pixels per line.
REQ-004 The block SHALL have parameter LINES, default 144: visible lines per frame.
REQ-005 The block SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 The block SHALL have port px_in, input, 2: pixel colour index from the PPU pixel FIFO.
REQ-008 The block SHALL have port px_valid, input, 1: px_in valid this cycle.
REQ-009 The block SHALL have port ppu_mode, input, 2: PPU mode, encoded H_BLANK=0, V_BLANK=1, SCAN=2, DRAW=3.
REQ-010 The block SHALL have port bgp, input, 8: BG palette register (FF47).
REQ-011 The block SHALL have port fb_wr_valid, output, 1: write request to framebuffer RAM.
REQ-012 The block SHALL have port fb_wr_ready, input, 1: RAM accepts the write this cycle.
REQ-013 The block SHALL have port fb_wr_addr, output, 13: framebuffer byte address.
REQ-014 The block SHALL have port fb_wr_data, output, 8: four packed 2-bit shades.
REQ-015 The block SHALL have port frame_done, output, 1: one-cycle pulse on V_BLANK entry.
REQ-016 The block SHALL have port line_count, output, 8: current line index.
REQ-017 The block SHALL have port overflow, output, 1: sticky flag, a byte was dropped on a full FIFO.

Function
REQ-018 Pixel acceptance SHALL require px_valid=1, ppu_mode=DRAW, x<LINE_PIXELS and line_count<LINES; every other px_valid is ignored.
REQ-019 Shade mapping SHALL be bgp[2*px_in+1 : 2*px_in], sampled in the accepting cycle.
REQ-020 Packing SHALL place the first pixel of each group in bits [7:6] and the fourth in [1:0]; x increments by 1 per accepted pixel.
REQ-021 On the fourth pixel of a group, the byte SHALL be pushed to the FIFO in the same edge.
REQ-022 The pushed address SHALL be FB_BASE + line_count*40 + (x>>2), 13-bit wrap-around.
REQ-023 A registered prev_mode SHALL be kept; line end is the event prev_mode=DRAW and ppu_mode!=DRAW.
REQ-024 At line end, a partial group (x%4!=0) SHALL be zero-padded in its low bits and pushed.
REQ-025 At line end, x SHALL clear to 0 and line_count SHALL increment, saturating at LINES.
REQ-026 Bytes for pixels never received on a short line SHALL NOT be written.
REQ-027 Frame end is the event prev_mode!=V_BLANK and ppu_mode=V_BLANK.
REQ-028 At frame end, frame_done SHALL be 1 for exactly one cycle, and line_count and x SHALL clear to 0, discarding any partial group.
REQ-029 If line end and frame end coincide, the line-end push SHALL occur and line_count SHALL finish at 0.
REQ-030 The FIFO SHALL be FIFO_DEPTH entries of {addr,data}, and fb_wr_valid SHALL equal FIFO not empty.
REQ-031 The FIFO head SHALL pop on fb_wr_valid&&fb_wr_ready.
REQ-032 fb_wr_addr/fb_wr_data SHALL be held stable while fb_wr_valid&&!fb_wr_ready.
REQ-033 A push into an empty FIFO SHALL raise fb_wr_valid on the next cycle (latency 1).
REQ-034 A push while full with no pop SHALL drop the byte and set overflow; a simultaneous push and pop while full SHALL accept the push.
REQ-035 Write order SHALL equal push order.

Reset
REQ-036 On rst, fb_wr_valid, frame_done, overflow, line_count, x and the partial byte SHALL be 0, the FIFO empty, and prev_mode=H_BLANK.
REQ-037 Reset mid-line SHALL discard all pending pixels and FIFO entries.
REQ-038 overflow SHALL clear only on rst.

Verification
REQ-039 bgp=E4, ready=1, line 0, DRAW, pixels 0,1,2,3 -> one cycle after the 4th: fb_wr_valid=1, addr=0x0000, data=0x1B.
REQ-040 bgp=1B, pixels 0,0,3,3 on line 2 -> addr=0x0050, data=0xF0.
REQ-041 ready=0, 20 pixels of 3 (5 bytes), bgp=E4 -> overflow=1; ready=1 -> exactly 4 writes of 0xFF at addresses 0..3.
REQ-042 6 pixels of 1 then DRAW->H_BLANK, bgp=E4 -> writes 0x55@0, then 0x50@1; line_count=1.
REQ-043 161 valid pixels in DRAW -> 40 writes (addresses 0..39); the 161st is dropped and overflow stays 0.
REQ-044 ppu_mode H_BLANK->V_BLANK -> frame_done high 1 cycle, line_count=0; rst mid-line with 2 pending pixels -> no write, all outputs 0.
